data_unpack_arbiter: RTL and testbench

//  Packet-level round-robin arbiter sharing one data_unpack instance between NUM_CH 32-bit

---
 rtl/data_unpack_arbiter.sv | 175 +++++++++++++++++
 tb/tb_data_unpack_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/data_unpack_arbiter.sv
// ============================================================================
// Module  : data_unpack_arbiter
// Brief   : Packet-level round-robin arbiter feeding one shared data_unpack core.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module data_unpack_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 32,
    parameter int DRAIN_TMO = 64,
    localparam int CH_W     = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        s_valid,
    input  logic [NUM_CH*DATA_W-1:0] s_data,
    input  logic [NUM_CH-1:0]        s_sop,
    input  logic [NUM_CH-1:0]        s_eop,
    output logic [NUM_CH-1:0]        s_ready,
    output logic                     m_valid,
    output logic [DATA_W-1:0]        m_data,
    output logic                     m_sop,
    output logic                     m_eop,
    input  logic                     m_ready,
    input  logic                     unpk_eop,
    output logic [CH_W-1:0]          out_ch,
    output logic                     busy,
    input  logic                     err_clr,
    output logic                     framing_err,
    output logic                     tmo_err
);

    localparam int CNT_W = (DRAIN_TMO > 2) ? $clog2(DRAIN_TMO) : 1;
    localparam logic [CNT_W-1:0] C_TMO_LAST = CNT_W'(DRAIN_TMO - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PASS  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CH_W-1:0]   r_grant, w_grant_nxt;
    logic [CH_W-1:0]   r_rr_ptr, w_rr_nxt;
    logic [CNT_W-1:0]  r_tmo_cnt, w_cnt_nxt;
    logic              r_first, w_first_nxt;
    logic              r_framing_err, r_tmo_err;
    logic              w_fr_set, w_tmo_set;

    logic [NUM_CH-1:0] w_elig;
    logic              w_any;
    logic [CH_W-1:0]   w_pick;
    logic [CH_W-1:0]   w_idx;
    int                w_sum;
    logic              w_acc;

    assign w_elig = s_valid & s_sop;

    // Scan from farthest to nearest so the nearest eligible after rr_ptr wins.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_sum  = 0;
        w_idx  = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            w_sum = int'(r_rr_ptr) + k;
            if (w_sum >= NUM_CH) begin
                w_sum = w_sum - NUM_CH;
            end
            w_idx = w_sum[CH_W-1:0];
            if (w_elig[w_idx]) begin
                w_any  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    assign w_acc = (r_state == S_PASS) && s_valid[r_grant] && m_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr_ptr;
        w_cnt_nxt   = r_tmo_cnt;
        w_first_nxt = r_first;
        w_fr_set    = 1'b0;
        w_tmo_set   = 1'b0;
        s_ready     = '0;
        m_valid     = 1'b0;
        m_data      = '0;
        m_sop       = 1'b0;
        m_eop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Mid-packet beats arriving with no owner are swallowed and flagged.
                s_ready  = s_valid & ~s_sop;
                w_fr_set = |(s_valid & ~s_sop);
                if (w_any) begin
                    w_grant_nxt = w_pick;
                    w_rr_nxt    = w_pick;
                    w_first_nxt = 1'b1;
                    w_state_nxt = S_PASS;
                end
            end
            S_PASS: begin
                m_valid          = s_valid[r_grant];
                m_data           = s_data[r_grant*DATA_W +: DATA_W];
                m_sop            = s_sop[r_grant];
                m_eop            = s_eop[r_grant];
                s_ready[r_grant] = m_ready;
                if (w_acc) begin
                    w_first_nxt = 1'b0;
                    if (s_sop[r_grant] && !r_first) begin
                        w_fr_set = 1'b1;
                    end
                    if (s_eop[r_grant]) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (unpk_eop) begin
                    w_state_nxt = S_IDLE;
                end else if (r_tmo_cnt == C_TMO_LAST) begin
                    w_tmo_set   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_tmo_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_rr_ptr      <= CH_W'(NUM_CH - 1);
            r_tmo_cnt     <= '0;
            r_first       <= 1'b0;
            r_framing_err <= 1'b0;
            r_tmo_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_rr_ptr  <= w_rr_nxt;
            r_tmo_cnt <= w_cnt_nxt;
            r_first   <= w_first_nxt;
            if (err_clr) begin
                r_framing_err <= 1'b0;
                r_tmo_err     <= 1'b0;
            end else begin
                if (w_fr_set) begin
                    r_framing_err <= 1'b1;
                end
                if (w_tmo_set) begin
                    r_tmo_err <= 1'b1;
                end
            end
        end
    end

    assign out_ch      = r_grant;
    assign busy        = (r_state != S_IDLE);
    assign framing_err = r_framing_err;
    assign tmo_err     = r_tmo_err;

endmodule

`default_nettype wire

// File: tb/tb_data_unpack_arbiter.sv
// ============================================================================
// Module  : tb_data_unpack_arbiter
// Brief   : Directed self-checking bench for data_unpack_arbiter (4 channels).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_data_unpack_arbiter;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH-1:0]        s_valid, s_sop, s_eop, s_ready;
    logic [NUM_CH*DATA_W-1:0] s_data;
    logic                     m_valid, m_sop, m_eop, m_ready;
    logic [DATA_W-1:0]        m_data;
    logic                     unpk_eop, busy, err_clr, framing_err, tmo_err;
    logic [1:0]               out_ch;

    int n_total = 0;
    int n_bad   = 0;

    data_unpack_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DRAIN_TMO(64)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_data(s_data), .s_sop(s_sop), .s_eop(s_eop), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_sop(m_sop), .m_eop(m_eop), .m_ready(m_ready),
        .unpk_eop(unpk_eop), .out_ch(out_ch), .busy(busy),
        .err_clr(err_clr), .framing_err(framing_err), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drv(input int ch, input logic v, input logic sop, input logic eop,
                       input logic [31:0] d);
        s_valid[ch]                = v;
        s_sop[ch]                  = sop;
        s_eop[ch]                  = eop;
        s_data[ch*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        s_valid = '0; s_sop = '0; s_eop = '0; s_data = '0;
        unpk_eop = 1'b0; err_clr = 1'b0; m_ready = 1'b1;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_ord [5];
        int         n;
        exp_ord = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};

        do_reset();
        settle();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        chk("rst_sready", 32'(s_ready), 32'd0);
        chk("rst_och", 32'(out_ch), 32'd0);
        chk("rst_ferr", 32'(framing_err), 32'd0);
        chk("rst_terr", 32'(tmo_err), 32'd0);

        // 1) ch0 three-beat packet
        drv(0, 1, 1, 0, 32'hA000_0001);
        settle();
        chk("t1_idle_rdy", 32'(s_ready), 32'd0);
        chk("t1_idle_mv", 32'(m_valid), 32'd0);
        tick(); settle();
        chk("t1_b1_mv", 32'(m_valid), 32'd1);
        chk("t1_b1_sop", 32'(m_sop), 32'd1);
        chk("t1_b1_data", m_data, 32'hA000_0001);
        chk("t1_b1_rdy", 32'(s_ready), 32'b0001);
        chk("t1_och", 32'(out_ch), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        tick(); drv(0, 1, 0, 0, 32'hA000_0002); settle();
        chk("t1_b2_sop", 32'(m_sop), 32'd0);
        chk("t1_b2_data", m_data, 32'hA000_0002);
        tick(); drv(0, 1, 0, 1, 32'hA000_0003); settle();
        chk("t1_b3_eop", 32'(m_eop), 32'd1);
        tick(); drv(0, 0, 0, 0, 32'h0); settle();
        chk("t1_drain_mv", 32'(m_valid), 32'd0);
        chk("t1_drain_busy", 32'(busy), 32'd1);
        tick(); tick();
        unpk_eop = 1'b1; settle();
        chk("t1_eop_och", 32'(out_ch), 32'd0);
        chk("t1_eop_busy", 32'(busy), 32'd1);
        tick(); unpk_eop = 1'b0; settle();
        chk("t1_idle_after", 32'(busy), 32'd0);

        // 2) ch0 and ch2 SOP together after reset
        do_reset();
        drv(0, 1, 1, 0, 32'hB000_0000);
        drv(2, 1, 1, 1, 32'hC000_0000);
        settle();
        chk("t2_idle_rdy", 32'(s_ready), 32'd0);
        tick(); settle();
        chk("t2_och0", 32'(out_ch), 32'd0);
        chk("t2_rdy0", 32'(s_ready), 32'b0001);
        chk("t2_d0", m_data, 32'hB000_0000);
        tick(); drv(0, 1, 0, 1, 32'hB000_0001); settle();
        chk("t2_d1", m_data, 32'hB000_0001);
        chk("t2_rdy1", 32'(s_ready), 32'b0001);
        tick(); drv(0, 0, 0, 0, 32'h0); settle();
        chk("t2_drain_mv", 32'(m_valid), 32'd0);
        chk("t2_drain_rdy", 32'(s_ready), 32'd0);
        unpk_eop = 1'b1;
        tick(); unpk_eop = 1'b0; settle();
        chk("t2_idle_busy", 32'(busy), 32'd0);
        tick(); settle();
        chk("t2_och2", 32'(out_ch), 32'd2);
        chk("t2_d2", m_data, 32'hC000_0000);
        chk("t2_sop2", 32'(m_sop), 32'd1);
        chk("t2_eop2", 32'(m_eop), 32'd1);
        tick(); drv(2, 0, 0, 0, 32'h0); unpk_eop = 1'b1;
        tick(); unpk_eop = 1'b0;

        // 3) ch0..2 continuous single-beat packets
        for (int c = 0; c < 3; c++) drv(c, 1, 1, 1, 32'hD000_0000 + 32'(c));
        for (int i = 0; i < 5; i++) begin
            tick(); settle();
            chk($sformatf("t3_och%0d", i), 32'(out_ch), 32'(exp_ord[i]));
            chk($sformatf("t3_data%0d", i), m_data, 32'hD000_0000 + 32'(exp_ord[i]));
            tick(); unpk_eop = 1'b1; settle();
            chk($sformatf("t3_drain%0d", i), 32'(m_valid), 32'd0);
            tick(); unpk_eop = 1'b0;
        end
        for (int c = 0; c < 3; c++) drv(c, 0, 0, 0, 32'h0);

        // 4) backpressure mid-packet on ch3
        drv(3, 1, 1, 0, 32'hE000_0000);
        tick(); settle();
        chk("t4_d0", m_data, 32'hE000_0000);
        tick(); drv(3, 1, 0, 0, 32'hE000_0001); m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk($sformatf("t4_hold_rdy%0d", i), 32'(s_ready), 32'd0);
            chk($sformatf("t4_hold_d%0d", i), m_data, 32'hE000_0001);
            tick();
        end
        m_ready = 1'b1; settle();
        chk("t4_resume_rdy", 32'(s_ready), 32'b1000);
        chk("t4_resume_mv", 32'(m_valid), 32'd1);
        tick(); drv(3, 1, 0, 1, 32'hE000_0002); settle();
        chk("t4_d2", m_data, 32'hE000_0002);
        chk("t4_och", 32'(out_ch), 32'd3);
        tick(); drv(3, 0, 0, 0, 32'h0); unpk_eop = 1'b1;
        tick(); unpk_eop = 1'b0;

        // 5) non-SOP beat in IDLE
        drv(1, 1, 0, 0, 32'hF000_0000); settle();
        chk("t5_rdy", 32'(s_ready), 32'b0010);
        chk("t5_mv", 32'(m_valid), 32'd0);
        tick(); drv(1, 0, 0, 0, 32'h0); settle();
        chk("t5_ferr", 32'(framing_err), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        err_clr = 1'b1;
        tick(); err_clr = 1'b0; settle();
        chk("t5_clr", 32'(framing_err), 32'd0);
        drv(1, 1, 0, 0, 32'hF000_0001); err_clr = 1'b1;
        tick(); drv(1, 0, 0, 0, 32'h0); err_clr = 1'b0; settle();
        chk("t5_clr_prio", 32'(framing_err), 32'd0);

        // 6) drain timeout, then reset mid-PASS
        drv(0, 1, 1, 1, 32'h0000_600D);
        tick(); tick(); drv(0, 0, 0, 0, 32'h0);
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        settle();
        chk("t6_tmo_cycles", 32'(n), 32'd64);
        chk("t6_tmo_err", 32'(tmo_err), 32'd1);
        drv(2, 1, 1, 0, 32'h0000_0077);
        tick(); settle();
        chk("t6_pass_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        tick(); settle();
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_mv", 32'(m_valid), 32'd0);
        chk("t6_rst_rdy", 32'(s_ready), 32'd0);
        chk("t6_rst_terr", 32'(tmo_err), 32'd0);
        rst = 1'b1;
        drv(2, 0, 0, 0, 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
